// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter (CPU vs. loader/DMA).
package data_mem_arbiter_pkg;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_t;

    localparam int unsigned DEF_DATA_W    = 32;
    localparam int unsigned DEF_ADDR_W    = 32;
    localparam int unsigned DEF_BURST_MAX = 8;

    localparam int unsigned           WAIT_CNT_W   = 16;
    localparam logic [WAIT_CNT_W-1:0] WAIT_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/arb_rr_core.sv
// Grant logic with last-winner priority state and DMA burst-lock counter.
// DATA_MEM_ARB_RR_EN selects round-robin unlocked arbitration; default is CPU-first.
module arb_rr_core
    import data_mem_arbiter_pkg::*;
#(
    parameter int unsigned BURST_MAX = DEF_BURST_MAX
) (
    input  logic clk,
    input  logic reset,
    input  logic cpu_req,
    input  logic dma_req,
    input  logic dma_lock,
    output logic cpu_gnt_c,
    output logic dma_gnt_c
);

    localparam int unsigned      CNT_W   = $clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);

    owner_t           last_winner;
    logic [CNT_W-1:0] burst_cnt;
    logic             locked;

    // A locked burst overrides everything until the counter is exhausted.
    always_comb begin
        cpu_gnt_c = 1'b0;
        dma_gnt_c = 1'b0;
        locked    = (last_winner == OWN_DMA) && dma_lock && dma_req && (burst_cnt < CNT_MAX);
        if (locked) begin
            dma_gnt_c = 1'b1;
        end else if (cpu_req && dma_req) begin
`ifdef DATA_MEM_ARB_RR_EN
            if (last_winner == OWN_CPU) begin
                dma_gnt_c = 1'b1;
            end else begin
                cpu_gnt_c = 1'b1;
            end
`else
            cpu_gnt_c = 1'b1;
`endif
        end else begin
            cpu_gnt_c = cpu_req;
            dma_gnt_c = dma_req;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_winner <= OWN_DMA;
            burst_cnt   <= '0;
        end else begin
            if (cpu_gnt_c) begin
                last_winner <= OWN_CPU;
            end else if (dma_gnt_c) begin
                last_winner <= OWN_DMA;
            end
            // Counter saturates so a lone DMA keeps running but yields at once to a CPU request.
            if (cpu_gnt_c || !dma_req) begin
                burst_cnt <= '0;
            end else if (dma_gnt_c && dma_lock && (burst_cnt != CNT_MAX)) begin
                burst_cnt <= burst_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one data-memory port between the CPU and a loader/DMA; read data is registered per requester.
// Optional macro DATA_MEM_ARB_RR_EN enables round-robin arbitration (see arb_rr_core).
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned BURST_MAX = DEF_BURST_MAX
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_W-1:0]     cpu_addr,
    input  logic [DATA_W-1:0]     cpu_wdata,
    output logic                  cpu_gnt,
    output logic                  cpu_stall,
    output logic                  cpu_rvalid,
    output logic [DATA_W-1:0]     cpu_rdata,
    input  logic                  dma_req,
    input  logic                  dma_we,
    input  logic                  dma_lock,
    input  logic [ADDR_W-1:0]     dma_addr,
    input  logic [DATA_W-1:0]     dma_wdata,
    output logic                  dma_gnt,
    output logic                  dma_rvalid,
    output logic [DATA_W-1:0]     dma_rdata,
    output logic                  mem_we,
    output logic                  mem_re,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic [WAIT_CNT_W-1:0] cpu_wait_cnt
);

    arb_rr_core #(
        .BURST_MAX (BURST_MAX)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .dma_req   (dma_req),
        .dma_lock  (dma_lock),
        .cpu_gnt_c (cpu_gnt),
        .dma_gnt_c (dma_gnt)
    );

    assign cpu_stall = cpu_req & ~cpu_gnt;

    // Memory port follows the granted requester; idle port is driven to zero.
    always_comb begin
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_re    = ~cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (dma_gnt) begin
            mem_we    = dma_we;
            mem_re    = ~dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_rvalid   <= 1'b0;
            cpu_rdata    <= '0;
            dma_rvalid   <= 1'b0;
            dma_rdata    <= '0;
            cpu_wait_cnt <= '0;
        end else begin
            cpu_rvalid <= cpu_gnt & ~cpu_we;
            dma_rvalid <= dma_gnt & ~dma_we;
            if (cpu_gnt && !cpu_we) begin
                cpu_rdata <= mem_rdata;
            end
            if (dma_gnt && !dma_we) begin
                dma_rdata <= mem_rdata;
            end
            if (cpu_stall && (cpu_wait_cnt != WAIT_CNT_MAX)) begin
                cpu_wait_cnt <= cpu_wait_cnt + WAIT_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: grants/mux checked per cycle, read data via per-requester queues.
module tb_data_mem_arbiter;

    typedef struct {
        int unsigned cyc;
        logic [31:0] data;
    } rd_exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic        dma_req = 1'b0, dma_we = 1'b0, dma_lock = 1'b0;
    logic [31:0] dma_addr = '0, dma_wdata = '0;
    logic        cpu_gnt, cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid;
    logic [31:0] cpu_rdata, dma_rdata;
    logic        mem_we, mem_re;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [15:0] cpu_wait_cnt;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned cyc = 0;
    logic [15:0] exp_wait = '0;
    rd_exp_t     cpu_q[$];
    rd_exp_t     dma_q[$];

    data_mem_arbiter dut (
        .clk (clk), .reset (reset),
        .cpu_req (cpu_req), .cpu_we (cpu_we), .cpu_addr (cpu_addr), .cpu_wdata (cpu_wdata),
        .cpu_gnt (cpu_gnt), .cpu_stall (cpu_stall), .cpu_rvalid (cpu_rvalid), .cpu_rdata (cpu_rdata),
        .dma_req (dma_req), .dma_we (dma_we), .dma_lock (dma_lock), .dma_addr (dma_addr),
        .dma_wdata (dma_wdata), .dma_gnt (dma_gnt), .dma_rvalid (dma_rvalid), .dma_rdata (dma_rdata),
        .mem_we (mem_we), .mem_re (mem_re), .mem_addr (mem_addr), .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata), .cpu_wait_cnt (cpu_wait_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEAD_BEEF : (a * 32'h9E37_79B1) + 32'h1;
    endfunction

    assign mem_rdata = mem_model(mem_addr);

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic set_cpu(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wd);
        cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    endtask

    task automatic set_dma(input logic req, input logic we, input logic lock,
                           input logic [31:0] addr, input logic [31:0] wd);
        dma_req = req; dma_we = we; dma_lock = lock; dma_addr = addr; dma_wdata = wd;
    endtask

    // Called just after a rising edge with inputs already driven; checks that cycle, then advances one clock.
    task automatic run_cycle(input string tag, input logic exp_c, input logic exp_d);
        logic [31:0] ea, ew;
        logic        ewe, ere;
        #1;
        ea  = exp_c ? cpu_addr  : (exp_d ? dma_addr  : 32'h0);
        ew  = exp_c ? cpu_wdata : (exp_d ? dma_wdata : 32'h0);
        ewe = exp_c ? cpu_we    : (exp_d ? dma_we    : 1'b0);
        ere = (exp_c && !cpu_we) || (exp_d && !dma_we);
        chk({tag, "_cpu_gnt"},  32'(cpu_gnt),   32'(exp_c));
        chk({tag, "_dma_gnt"},  32'(dma_gnt),   32'(exp_d));
        chk({tag, "_stall"},    32'(cpu_stall), 32'(cpu_req & ~exp_c));
        chk({tag, "_mem_we"},   32'(mem_we),    32'(ewe));
        chk({tag, "_mem_re"},   32'(mem_re),    32'(ere));
        chk({tag, "_mem_addr"}, mem_addr,  ea);
        chk({tag, "_mem_wd"},   mem_wdata, ew);
        if (exp_c && !cpu_we) cpu_q.push_back('{cyc, mem_model(cpu_addr)});
        if (exp_d && !dma_we) dma_q.push_back('{cyc, mem_model(dma_addr)});
        if (cpu_req && !exp_c && exp_wait != 16'hFFFF) exp_wait++;
        @(posedge clk);
        #1;
        chk({tag, "_wait_cnt"}, 32'(cpu_wait_cnt), 32'(exp_wait));
    endtask

    // Read-return monitor: rvalid must rise exactly one cycle after a granted read.
    always @(negedge clk) begin : mon
        logic cv, dv;
        cv = (cpu_q.size() > 0) && (cpu_q[0].cyc == cyc - 1);
        dv = (dma_q.size() > 0) && (dma_q[0].cyc == cyc - 1);
        chk("cpu_rvalid", 32'(cpu_rvalid), 32'(cv));
        chk("dma_rvalid", 32'(dma_rvalid), 32'(dv));
        if (cv) begin
            chk("cpu_rdata", cpu_rdata, cpu_q[0].data);
            void'(cpu_q.pop_front());
        end
        if (dv) begin
            chk("dma_rdata", dma_rdata, dma_q[0].data);
            void'(dma_q.pop_front());
        end
    end

    initial begin
        int guard;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cpu_rdata", cpu_rdata, 32'h0);
        chk("rst_dma_rdata", dma_rdata, 32'h0);
        chk("rst_wait_cnt", 32'(cpu_wait_cnt), 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;

        // Single CPU read, then hold check on cpu_rdata
        set_cpu(1'b1, 1'b0, 32'h10, 32'h0);
        run_cycle("cpu_rd", 1'b1, 1'b0);
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        run_cycle("idle_a", 1'b0, 1'b0);
        chk("cpu_rdata_hold", cpu_rdata, 32'hDEAD_BEEF);

        set_cpu(1'b1, 1'b1, 32'h20, 32'h1234_5678);
        run_cycle("cpu_wr", 1'b1, 1'b0);
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        set_dma(1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
        run_cycle("dma_rd", 1'b0, 1'b1);
        set_dma(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        run_cycle("idle_b", 1'b0, 1'b0);
        chk("cpu_rdata_hold2", cpu_rdata, 32'hDEAD_BEEF);

        // Contested, unlocked; last winner is DMA at this point
        set_cpu(1'b1, 1'b0, 32'h44, 32'h0);
        set_dma(1'b1, 1'b0, 1'b0, 32'h48, 32'h0);
`ifdef DATA_MEM_ARB_RR_EN
        for (int i = 0; i < 4; i++) run_cycle("rr", (i % 2) == 0, (i % 2) == 1);
        chk("rr_wait_cnt", 32'(cpu_wait_cnt), 32'd2);
`else
        for (int i = 0; i < 5; i++) run_cycle("fixed", 1'b1, 1'b0);
        chk("fixed_wait_cnt", 32'(cpu_wait_cnt), 32'd0);
`endif
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        set_dma(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        run_cycle("idle_c", 1'b0, 1'b0);

        // Establish DMA as last winner, then a locked burst against a waiting CPU
        set_dma(1'b1, 1'b1, 1'b0, 32'h100, 32'hA0);
        run_cycle("dma_solo", 1'b0, 1'b1);
        set_dma(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        run_cycle("idle_d", 1'b0, 1'b0);
        set_dma(1'b1, 1'b1, 1'b1, 32'h200, 32'hB0);
        set_cpu(1'b1, 1'b0, 32'h80, 32'h0);
        for (int i = 0; i < 8; i++) run_cycle("burst", 1'b0, 1'b1);
        run_cycle("burst_cpu", 1'b1, 1'b0);
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 10; i++) run_cycle("resume", 1'b0, 1'b1);
        // Counter is saturated: a new CPU request wins immediately
        set_cpu(1'b1, 1'b1, 32'h84, 32'hC0);
        run_cycle("sat_cpu", 1'b1, 1'b0);
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        set_dma(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        run_cycle("idle_e", 1'b0, 1'b0);

        // Repeated bursts until the stall counter saturates, then a few more periods
        set_dma(1'b1, 1'b1, 1'b1, 32'h300, 32'hD0);
        guard = 0;
        while (guard < 10010) begin
            if (exp_wait == 16'hFFFF && guard >= 3) break;
            if (exp_wait == 16'hFFFF) guard++;
            else if (guard > 10000) break;
            set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
            run_cycle("sp_d0", 1'b0, 1'b1);
            set_cpu(1'b1, 1'b1, 32'h88, 32'hE0);
            repeat (7) run_cycle("sp_ds", 1'b0, 1'b1);
            run_cycle("sp_c", 1'b1, 1'b0);
        end
        chk("wait_saturated", 32'(cpu_wait_cnt), 32'h0000_FFFF);

        // Reset asserted during a granted DMA read
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        set_dma(1'b1, 1'b0, 1'b0, 32'h400, 32'h0);
        #1;
        chk("rst_dma_gnt", 32'(dma_gnt), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        exp_wait = '0;
        chk("arst_wait_cnt", 32'(cpu_wait_cnt), 32'h0);
        chk("arst_dma_rvalid", 32'(dma_rvalid), 32'h0);
        chk("arst_cpu_rdata", cpu_rdata, 32'h0);
        chk("arst_dma_rdata", dma_rdata, 32'h0);
        set_dma(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_dma_rvalid", 32'(dma_rvalid), 32'h0);
        chk("post_rst_wait_cnt", 32'(cpu_wait_cnt), 32'h0);
        set_cpu(1'b1, 1'b0, 32'h10, 32'h0);
        set_dma(1'b1, 1'b0, 1'b0, 32'h48, 32'h0);
        run_cycle("post_rst", 1'b1, 1'b0);
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        set_dma(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        run_cycle("idle_f", 1'b0, 1'b0);
        run_cycle("idle_g", 1'b0, 1'b0);
        chk("cpu_q_drained", cpu_q.size(), 32'd0);
        chk("dma_q_drained", dma_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
